// File: rtl/fifo_uart_if.sv
// Register-bus port of the buffered UART: one address and two strobes,
// write data in and registered read data out.
interface fifo_uart_if #(
    parameter int address_width = 8,
    parameter int width         = 8
);
    logic [address_width-1:0] active_address;
    logic                     write_enable;
    logic                     read_enable;
    logic [width-1:0]         data_in;
    logic [width-1:0]         data_out;

    modport master (
        output active_address, write_enable, read_enable, data_in,
        input  data_out
    );
    modport slave (
        input  active_address, write_enable, read_enable, data_in,
        output data_out
    );
endinterface

// File: rtl/fifo_uart.sv
// Buffered UART: TX FIFO -> serializer, deserializer -> RX FIFO, with a status
// register holding sticky framing/parity/overrun bits and a level interrupt.
module fifo_uart #(
    parameter int clock_freq     = 50_000_000,
    parameter int baud_rate      = 115_200,
    parameter int width          = 8,
    parameter int depth          = 16,
    parameter int parity_mode    = 0,
    parameter int address_width  = 8,
    parameter int rx_address     = 3,
    parameter int tx_address     = 4,
    parameter int status_address = 5
) (
    input  logic       clock,
    input  logic       reset,
    fifo_uart_if.slave bus,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);
    localparam int TPB = clock_freq / baud_rate;
    localparam int CW  = $clog2(TPB + 1);
    localparam int AW  = $clog2(depth);
    localparam int BW  = $clog2(width);
    localparam logic [CW-1:0] LAST   = CW'(TPB - 1);
    localparam logic [CW-1:0] HALF   = CW'(TPB / 2 - 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(depth);
    localparam logic [BW-1:0] LASTB  = BW'(width - 1);
    localparam logic          ODD    = (parity_mode == 2);
    localparam logic          PAR_EN = (parity_mode != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    logic rd_en, wr_tx, rd_rx, rd_st;
    assign rd_en = bus.read_enable && !bus.write_enable;
    assign wr_tx = bus.write_enable && (bus.active_address == address_width'(tx_address));
    assign rd_rx = rd_en && (bus.active_address == address_width'(rx_address));
    assign rd_st = rd_en && (bus.active_address == address_width'(status_address));

    // ---------------- TX FIFO ----------------
    logic [width-1:0] txm_q [depth];
    logic [AW-1:0]    txw_q, txr_q;
    logic [AW:0]      txc_q;
    logic             tx_push, tx_pop;

    assign tx_push = wr_tx && (txc_q != FULL);

    always_ff @(posedge clock)
        if (tx_push) txm_q[txw_q] <= bus.data_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            txw_q <= '0;
            txr_q <= '0;
            txc_q <= '0;
        end else begin
            if (tx_push) txw_q <= txw_q + AW'(1);
            if (tx_pop)  txr_q <= txr_q + AW'(1);
            txc_q <= txc_q + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
        end
    end

    // ---------------- TX serializer ----------------
    state_e           tx_st_q;
    logic [CW-1:0]    tx_cnt_q;
    logic [BW-1:0]    tx_bit_q;
    logic [width-1:0] tx_sh_q;
    logic             tx_par_q, tx_q, tx_end, tx_line;

    assign tx_end = (tx_cnt_q == LAST);
    assign tx_pop = (txc_q != '0) && (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_end));

    always_comb begin
        tx_line = 1'b1;
        case (tx_st_q)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_sh_q[0];
            S_PAR:   tx_line = tx_par_q;
            default: tx_line = 1'b1;
        endcase
    end

    // tx_q lags the state by one cycle, giving the write-to-start-bit latency of two
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_q     <= tx_line;
            tx_cnt_q <= (tx_st_q == S_IDLE || tx_end) ? '0 : tx_cnt_q + CW'(1);
            if (tx_pop) begin
                tx_st_q  <= S_START;
                tx_sh_q  <= txm_q[txr_q];
                tx_par_q <= (^txm_q[txr_q]) ^ ODD;
            end else if (tx_end) begin
                case (tx_st_q)
                    S_START: begin
                        tx_st_q  <= S_DATA;
                        tx_bit_q <= '0;
                    end
                    S_DATA: begin
                        tx_sh_q <= tx_sh_q >> 1;
                        if (tx_bit_q == LASTB) tx_st_q <= PAR_EN ? S_PAR : S_STOP;
                        else                   tx_bit_q <= tx_bit_q + BW'(1);
                    end
                    S_PAR:   tx_st_q <= S_STOP;
                    default: tx_st_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx = tx_q;

    // ---------------- RX deserializer ----------------
    state_e           rx_st_q;
    logic [CW-1:0]    rx_cnt_q;
    logic [BW-1:0]    rx_bit_q;
    logic [width-1:0] rx_sh_q;
    logic             s1_q, s2_q, prev_q, rx_end;
    logic             rx_pbad_q, rx_done_q, ferr_set_q, perr_set_q;

    assign rx_end = (rx_cnt_q == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            prev_q     <= 1'b1;
            rx_st_q    <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_pbad_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
        end else begin
            s1_q       <= rx;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            rx_done_q  <= 1'b0;
            ferr_set_q <= 1'b0;
            perr_set_q <= 1'b0;
            rx_cnt_q   <= rx_cnt_q + CW'(1);
            case (rx_st_q)
                S_IDLE: begin
                    rx_cnt_q <= '0;
                    if (prev_q && !s2_q) rx_st_q <= S_START;
                end
                S_START: if (rx_cnt_q == HALF) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= s2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_end) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {s2_q, rx_sh_q[width-1:1]};
                    if (rx_bit_q == LASTB) rx_st_q <= PAR_EN ? S_PAR : S_STOP;
                    else                   rx_bit_q <= rx_bit_q + BW'(1);
                end
                S_PAR: if (rx_end) begin
                    rx_cnt_q  <= '0;
                    rx_pbad_q <= s2_q ^ (^rx_sh_q) ^ ODD;
                    rx_st_q   <= S_STOP;
                end
                default: if (rx_end) begin
                    rx_cnt_q   <= '0;
                    rx_st_q    <= S_IDLE;
                    ferr_set_q <= !s2_q;
                    perr_set_q <= PAR_EN && rx_pbad_q;
                    rx_done_q  <= s2_q && !(PAR_EN && rx_pbad_q);
                end
            endcase
        end
    end

    // ---------------- RX FIFO, status, read port ----------------
    logic [width-1:0] rxm_q [depth];
    logic [AW-1:0]    rxw_q, rxr_q;
    logic [AW:0]      rxc_q;
    logic             rx_push, rx_pop, ovr_set;
    logic             ferr_q, perr_q, ovr_q;
    logic [width-1:0] status, dout_q;

    assign rx_push = rx_done_q && (rxc_q != FULL);
    assign ovr_set = rx_done_q && (rxc_q == FULL);
    assign rx_pop  = rd_rx && (rxc_q != '0);

    always_ff @(posedge clock)
        if (rx_push) rxm_q[rxw_q] <= rx_sh_q;

    assign status = width'({tx_st_q != S_IDLE, perr_q, ferr_q, ovr_q,
                            rxc_q == '0, rxc_q == FULL, txc_q == '0, txc_q == FULL});

    always_ff @(posedge clock) begin
        if (reset) begin
            rxw_q  <= '0;
            rxr_q  <= '0;
            rxc_q  <= '0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            if (rx_push) rxw_q <= rxw_q + AW'(1);
            if (rx_pop)  rxr_q <= rxr_q + AW'(1);
            rxc_q <= rxc_q + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
            // a new error in the clearing cycle survives the clear
            ferr_q <= (ferr_q && !rd_st) || ferr_set_q;
            perr_q <= (perr_q && !rd_st) || perr_set_q;
            ovr_q  <= (ovr_q  && !rd_st) || ovr_set;
            if (rd_en) begin
                if (rd_rx)      dout_q <= (rxc_q != '0) ? rxm_q[rxr_q] : '0;
                else if (rd_st) dout_q <= status;
                else            dout_q <= '0;
            end
        end
    end

    assign bus.data_out = dout_q;
    assign irq = (rxc_q != '0) || ferr_q || perr_q || ovr_q;
endmodule

// File: tb/tb_fifo_uart.sv
// Randomized bench for fifo_uart: a line decoder on tx and queue models of the
// TX/RX FIFOs predict frames, read data and status.
module tb_fifo_uart;
    localparam int TPB = 8;
    localparam int W   = 8;
    localparam int D   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    fifo_uart_if #(.address_width(8), .width(W)) bus_a ();
    fifo_uart_if #(.address_width(8), .width(W)) bus_b ();

    logic loop = 1'b0;
    logic rxd_a = 1'b1;
    logic rxd_b = 1'b1;
    logic rx_a, tx_a, irq_a, tx_b, irq_b;
    assign rx_a = loop ? tx_a : rxd_a;

    fifo_uart #(.clock_freq(800), .baud_rate(100), .width(W), .depth(D), .parity_mode(0),
                .address_width(8), .rx_address(3), .tx_address(4), .status_address(5))
    dut_a (.clock(clk), .reset(rst), .bus(bus_a.slave), .rx(rx_a), .tx(tx_a), .irq(irq_a));

    fifo_uart #(.clock_freq(800), .baud_rate(100), .width(W), .depth(D), .parity_mode(1),
                .address_width(8), .rx_address(3), .tx_address(4), .status_address(5))
    dut_b (.clock(clk), .reset(rst), .bus(bus_b.slave), .rx(rxd_b), .tx(tx_b), .irq(irq_b));

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] tx_exp [$];
    logic [7:0] rx_mod [$];
    int         tx_starts [$];
    bit         ovr_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic bus_op(input bit b, input logic [7:0] addr, input bit wr,
                          input logic [7:0] din, output logic [7:0] dout);
        @(negedge clk);
        if (b) begin
            bus_b.active_address = addr; bus_b.write_enable = wr;
            bus_b.read_enable = !wr;     bus_b.data_in = din;
        end else begin
            bus_a.active_address = addr; bus_a.write_enable = wr;
            bus_a.read_enable = !wr;     bus_a.data_in = din;
        end
        @(negedge clk);
        bus_a.write_enable = 1'b0; bus_a.read_enable = 1'b0;
        bus_b.write_enable = 1'b0; bus_b.read_enable = 1'b0;
        dout = b ? bus_b.data_out : bus_a.data_out;
    endtask

    task automatic wr(input bit b, input logic [7:0] d);
        logic [7:0] unused;
        bus_op(b, 8'd4, 1'b1, d, unused);
    endtask

    task automatic rd(input bit b, input logic [7:0] addr, output logic [7:0] d);
        bus_op(b, addr, 1'b0, 8'h00, d);
    endtask

    // Model: a word accepted by TX reappears on the line; in loopback it lands in RX
    task automatic expect_tx(input logic [7:0] d);
        tx_exp.push_back(d);
        if (loop) begin
            if (rx_mod.size() < D) rx_mod.push_back(d);
            else ovr_exp = 1'b1;
        end
    endtask

    function automatic logic [7:0] stat_a();
        return 8'h02 | (rx_mod.size() == 0 ? 8'h08 : 8'h00)
                     | (rx_mod.size() == D ? 8'h04 : 8'h00)
                     | (ovr_exp ? 8'h10 : 8'h00);
    endfunction

    task automatic drive_bit(input bit b, input logic v);
        if (b) rxd_b = v; else rxd_a = v;
        repeat (TPB) @(negedge clk);
    endtask

    task automatic send_rx(input bit b, input logic [7:0] d, input bit use_par,
                           input bit par, input bit stop);
        @(negedge clk);
        drive_bit(b, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b, d[i]);
        if (use_par) drive_bit(b, par);
        drive_bit(b, stop);
        drive_bit(b, 1'b1);
    endtask

    task automatic wait_tx_drain(input int limit);
        int t = 0;
        while (tx_exp.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("tx_drain", 32'(tx_exp.size()), 32'd0);
    endtask

    // Line decoder: every bit must hold for exactly TPB cycles
    initial begin : tx_mon
        logic [9:0] bv;
        logic [7:0] e;
        bit ok, ab;
        forever begin
            @(negedge clk);
            if (!rst && tx_a === 1'b0) begin
                tx_starts.push_back(cyc);
                ok = 1'b1; ab = 1'b0; bv = '0;
                for (int b = 0; b < 10 && !ab; b++)
                    for (int k = 0; k < TPB && !ab; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst) ab = 1'b1;
                        else if (k == 0) bv[b] = tx_a;
                        else if (tx_a !== bv[b]) ok = 1'b0;
                    end
                if (ab) begin
                    if (tx_exp.size() > 0) void'(tx_exp.pop_front());
                end else begin
                    e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
                    chk("tx_frame", 32'({ok, bv}), 32'({1'b1, 1'b1, e, 1'b0}));
                end
            end
        end
    end

    initial begin : main
        logic [7:0] v, d, w0;
        logic [7:0] burst [D+1];

        bus_a.active_address = '0; bus_a.write_enable = 1'b0;
        bus_a.read_enable = 1'b0;  bus_a.data_in = '0;
        bus_b.active_address = '0; bus_b.write_enable = 1'b0;
        bus_b.read_enable = 1'b0;  bus_b.data_in = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_irq", 32'(irq_a), 32'd0);
        chk("rst_dout", 32'(bus_a.data_out), 32'd0);
        rd(0, 8'd5, v); chk("rst_stat_a", 32'(v), 32'h0A);
        rd(1, 8'd5, v); chk("rst_stat_b", 32'(v), 32'h0A);

        // loopback single frame
        loop = 1'b1;
        expect_tx(8'hA5);
        wr(0, 8'hA5);
        wait_tx_drain(400);
        repeat (TPB) @(negedge clk);
        rd(0, 8'd3, v); chk("loop_rx", 32'(v), 32'(rx_mod.pop_front()));
        rd(0, 8'd5, v); chk("loop_stat", 32'(v), 32'(stat_a()));

        // write-to-start latency
        w0 = 8'($urandom);
        expect_tx(w0);
        wr(0, w0);
        @(negedge clk); chk("lat_n1", 32'(tx_a), 32'd1);
        @(negedge clk); chk("lat_n2", 32'(tx_a), 32'd0);

        // burst of depth+1 while w0 is on the line
        for (int i = 0; i <= D; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            bus_a.active_address = 8'd4; bus_a.write_enable = 1'b1; bus_a.data_in = burst[i];
            expect_tx(burst[i]);
        end
        @(negedge clk);
        bus_a.write_enable = 1'b0; bus_a.read_enable = 1'b1; bus_a.active_address = 8'd5;
        @(negedge clk);
        chk("burst_full_stat", 32'(bus_a.data_out), 32'h89);
        bus_a.read_enable = 1'b0; bus_a.write_enable = 1'b1;
        bus_a.active_address = 8'd4; bus_a.data_in = burst[D];
        @(negedge clk);
        bus_a.write_enable = 1'b0;
        wait_tx_drain(3000);
        repeat (2 * TPB) @(negedge clk);
        chk("nframes", 32'(tx_starts.size()), 32'd18);
        for (int i = 2; i < 18 && i < tx_starts.size(); i++)
            chk("gap", 32'(tx_starts[i] - tx_starts[i-1]), 32'(10 * TPB));

        // overrun and its clear-on-read
        chk("ovr_irq", 32'(irq_a), 32'd1);
        rd(0, 8'd5, v); chk("ovr_stat1", 32'(v), 32'(stat_a()));
        ovr_exp = 1'b0;
        rd(0, 8'd5, v); chk("ovr_stat2", 32'(v), 32'(stat_a()));
        for (int i = 0; i < D; i++) begin
            rd(0, 8'd3, v); chk("drain", 32'(v), 32'(rx_mod.pop_front()));
        end
        rd(0, 8'd5, v); chk("drain_stat", 32'(v), 32'h0A);
        chk("drain_irq", 32'(irq_a), 32'd0);
        rd(0, 8'd3, v); chk("empty_rd", 32'(v), 32'd0);
        loop = 1'b0;

        // framing error
        d = 8'($urandom);
        send_rx(0, d, 1'b0, 1'b0, 1'b0);
        repeat (2 * TPB) @(negedge clk);
        chk("ferr_irq", 32'(irq_a), 32'd1);
        rd(0, 8'd5, v); chk("ferr_stat", 32'(v), 32'h2A);
        rd(0, 8'd5, v); chk("ferr_clr", 32'(v), 32'h0A);

        // good driven frames
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            send_rx(0, d, 1'b0, 1'b0, 1'b1);
            rd(0, 8'd3, v); chk("drv_rx", 32'(v), 32'(d));
        end

        // short low glitch
        @(negedge clk);
        rxd_a = 1'b0;
        repeat (TPB / 4) @(negedge clk);
        rxd_a = 1'b1;
        repeat (3 * TPB) @(negedge clk);
        chk("glitch_irq", 32'(irq_a), 32'd0);
        rd(0, 8'd5, v); chk("glitch_stat", 32'(v), 32'h0A);

        // even parity on dut_b
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            send_rx(1, d, 1'b1, ^d, 1'b1);
            rd(1, 8'd3, v); chk("par_rx", 32'(v), 32'(d));
        end
        d = 8'($urandom);
        send_rx(1, d, 1'b1, ~^d, 1'b1);
        chk("perr_irq", 32'(irq_b), 32'd1);
        rd(1, 8'd5, v); chk("perr_stat", 32'(v), 32'h4A);
        rd(1, 8'd3, v); chk("perr_drop", 32'(v), 32'd0);

        // reset in the middle of the data bits
        d = 8'($urandom);
        expect_tx(d);
        wr(0, d);
        repeat (2 + 4 * TPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); chk("rst_mid_tx", 32'(tx_a), 32'd1);
        @(negedge clk); rst = 1'b0;
        rd(0, 8'd5, v); chk("rst_mid_stat", 32'(v), 32'h0A);
        chk("rst_abort", 32'(tx_exp.size()), 32'd0);
        d = 8'($urandom);
        expect_tx(d);
        wr(0, d);
        wait_tx_drain(400);
        repeat (TPB) @(negedge clk);
        rd(0, 8'd5, v); chk("final_stat", 32'(v), 32'h0A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
